// File: rtl/activation_buffer_array.sv
// rtl/activation_buffer_array.sv - per-lane activation memories with skewed streaming read-out
module activation_buffer_array #(
  parameter int LANES   = 32,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 2048,
  parameter int HOST_W  = 32,
  parameter int BATCH_W = 6,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LPW    = HOST_W / DATA_W,
  localparam int NGRP   = LANES / LPW,
  localparam int GRP_W  = (NGRP > 1) ? $clog2(NGRP) : 1,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int BPL    = DATA_W / 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      h_en,
  input  logic [HOST_W/8-1:0]       h_we,
  input  logic [ADDR_W-1:0]         h_row,
  input  logic [GRP_W-1:0]          h_grp,
  input  logic [HOST_W-1:0]         h_din,
  output logic [HOST_W-1:0]         h_dout,
  input  logic                      w_en,
  input  logic [LANES*DATA_W/8-1:0] w_we,
  input  logic [ADDR_W-1:0]         w_row,
  input  logic [LANES*DATA_W-1:0]   w_din,
  input  logic                      start,
  input  logic [LANE_W-1:0]         last_lane,
  input  logic [ADDR_W-1:0]         addr_start,
  input  logic [BATCH_W-1:0]        batch,
  input  logic                      stall,
  output logic [LANES*DATA_W-1:0]   activation_out,
  output logic [LANES-1:0]          activation_valid,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [LANES-1:0]          r_tok;
  logic [ADDR_W-1:0]         r_astart;
  logic [BATCH_W-1:0]        r_batch;
  logic                      r_nrd_d1;
  logic [GRP_W-1:0]          r_grp_d1;
  logic [HOST_W-1:0]         r_h_dout;
  logic [LANES*DATA_W-1:0]   w_act;
  logic [LANES-1:0]          w_vld;
  logic [LANES-1:0]          w_pend;
  logic                      w_busy;
  logic                      w_start_acc;
  logic                      w_wide_wr;
  logic                      w_nar_acc;
  logic                      w_nar_rd;
  logic                      w_last_acc;

  function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  assign w_busy      = (r_state != S_IDLE);
  assign w_start_acc = (r_state == S_IDLE) && start;
  // Host ports are locked out while streaming; the wide port takes priority.
  assign w_wide_wr   = !w_busy && w_en;
  assign w_nar_acc   = !w_busy && h_en && !w_en;
  assign w_nar_rd    = w_nar_acc && (h_we == '0);
  // Lane 0 is always the last lane to finish, so its final accepted beat ends the run.
  assign w_last_acc  = (r_state == S_RUN) && w_vld[0] && !stall && !w_pend[0];

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; an empty batch goes straight to DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = (batch == '0) ? S_DONE : S_RUN;
      S_RUN:  if (w_last_acc) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture run parameters when a start is accepted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_astart <= '0;
      r_batch  <= '0;
    end else if (w_start_acc) begin
      r_astart <= addr_start;
      r_batch  <= batch;
    end
  end

  // Skew token: one-hot, injected at the highest active lane and walking down one lane per cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                           r_tok <= '0;
    else if (w_start_acc && batch != '0)   r_tok <= LANES'(1) << last_lane;
    else if (!stall)                       r_tok <= r_tok >> 1;
  end

  // Narrow read pipeline: RAM read in T, group select registered into h_dout in T+1
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_nrd_d1 <= 1'b0;
      r_grp_d1 <= '0;
      r_h_dout <= '0;
    end else begin
      r_nrd_d1 <= w_nar_rd;
      r_grp_d1 <= h_grp;
      if (r_nrd_d1 && !w_busy) r_h_dout <= w_act[r_grp_d1 * HOST_W +: HOST_W];
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int K = gi % LPW;
    localparam logic [GRP_W-1:0] GRP = GRP_W'(gi / LPW);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0]  r_q;
    logic               r_run;
    logic               r_vld;
    logic [BATCH_W-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic               w_we_l;
    logic               w_pend_l;
    logic               w_srd;
    logic               w_rd;
    logic [ADDR_W-1:0]  w_wa;
    logic [ADDR_W-1:0]  w_ra;
    logic [DATA_W-1:0]  w_wd;

    assign w_we_l   = w_wide_wr ? |w_we[gi*BPL +: BPL]
                                : (w_nar_acc && (h_grp == GRP) && |h_we[K*BPL +: BPL]);
    assign w_wd     = w_en ? w_din[gi*DATA_W +: DATA_W] : h_din[K*DATA_W +: DATA_W];
    assign w_wa     = w_en ? w_row : h_row;
    assign w_pend_l = r_tok[gi] | r_run;
    assign w_srd    = w_pend_l & ~stall;
    assign w_rd     = w_srd | w_nar_rd;
    assign w_ra     = w_nar_rd ? h_row : (r_tok[gi] ? r_astart : r_addr);

    // Lane memory write port
    always_ff @(posedge clk) begin
      if (w_we_l) r_mem[w_wa] <= w_wd;
    end

    // Registered read data doubles as the lane's output register; it holds whenever no read is issued
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   r_q <= '0;
      else if (w_rd) r_q <= r_mem[w_ra];
    end

    // Lane read sequencer: token issues the first read, counter issues the remaining batch-1
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_run  <= 1'b0;
        r_vld  <= 1'b0;
        r_cnt  <= '0;
        r_addr <= '0;
      end else if (!stall) begin
        r_vld <= w_pend_l;
        if (r_tok[gi]) begin
          r_run  <= (r_batch != BATCH_W'(1));
          r_cnt  <= BATCH_W'(1);
          r_addr <= f_next(r_astart);
        end else if (r_run) begin
          r_run  <= ((r_cnt + BATCH_W'(1)) != r_batch);
          r_cnt  <= r_cnt + BATCH_W'(1);
          r_addr <= f_next(r_addr);
        end
      end
    end

    assign w_act[gi*DATA_W +: DATA_W] = r_q;
    assign w_vld[gi]                  = r_vld;
    assign w_pend[gi]                 = w_pend_l;
  end

  assign h_dout           = r_h_dout;
  assign activation_out   = w_act;
  assign activation_valid = w_vld & {LANES{~stall}};
  assign busy             = w_busy;
  assign done             = (r_state == S_DONE);

endmodule
